// File: rtl/asg_seq_pkg.sv
// Shared definitions for the ASG segment scheduler: FSM encoding and descriptor layout.
package asg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } sched_state_t;

    localparam int NCYC_W = 16;
    localparam int AMP_W  = 14;
    localparam int DC_W   = 14;
    localparam int PH_W   = 2;

    function automatic int ptr_w(input int rsz);
        return rsz + 16;
    endfunction

    // Pointer fields scale with RSZ, so they travel beside this struct rather than inside it.
    typedef struct packed {
        logic [NCYC_W-1:0] ncyc;
        logic [AMP_W-1:0]  amp;
        logic [DC_W-1:0]   dc;
        logic [PH_W-1:0]   phase;
        logic              last;
    } seg_desc_t;

endpackage

// File: rtl/asg_slot_ring.sv
// Ring of channel configuration slots with write/play pointers, occupancy and bus packing.
module asg_slot_ring
    import asg_seq_pkg::*;
#(
    parameter int RSZ   = 14,
    parameter int N_BUF = 4,
    parameter int SW    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ptr_w(RSZ)-1:0]         wr_start,
    input  logic [ptr_w(RSZ)-1:0]         wr_end,
    input  logic [ptr_w(RSZ)-1:0]         wr_step,
    input  seg_desc_t                     wr_cfg,
    input  logic                          play_adv,
    input  logic                          play_reset,
    input  logic                          clear,
    output logic [SW:0]                   occ,
    output logic                          play_last,
    output logic [ptr_w(RSZ)*N_BUF-1:0]   start_all,
    output logic [ptr_w(RSZ)*N_BUF-1:0]   end_all,
    output logic [ptr_w(RSZ)*N_BUF-1:0]   step_all,
    output logic [NCYC_W*N_BUF-1:0]       ncyc_all,
    output logic [AMP_W*N_BUF-1:0]        amp_all,
    output logic [DC_W*N_BUF-1:0]         dc_all,
    output logic [PH_W*N_BUF-1:0]         phase_all
);
    localparam int PW = ptr_w(RSZ);

    logic [SW-1:0]     wr_slot;
    logic [SW-1:0]     play_slot;
    logic [N_BUF-1:0]  last_q;
    logic [PW-1:0]     start_q [N_BUF];
    logic [PW-1:0]     end_q   [N_BUF];
    logic [PW-1:0]     step_q  [N_BUF];
    logic [NCYC_W-1:0] ncyc_q  [N_BUF];
    logic [AMP_W-1:0]  amp_q   [N_BUF];
    logic [DC_W-1:0]   dc_q    [N_BUF];
    logic [PH_W-1:0]   phase_q [N_BUF];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot   <= '0;
            play_slot <= '0;
            occ       <= '0;
            last_q    <= '0;
            for (int i = 0; i < N_BUF; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                step_q[i]  <= '0;
                ncyc_q[i]  <= '0;
                amp_q[i]   <= '0;
                dc_q[i]    <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                start_q[wr_slot] <= wr_start;
                end_q[wr_slot]   <= wr_end;
                step_q[wr_slot]  <= wr_step;
                ncyc_q[wr_slot]  <= wr_cfg.ncyc;
                amp_q[wr_slot]   <= wr_cfg.amp;
                dc_q[wr_slot]    <= wr_cfg.dc;
                phase_q[wr_slot] <= wr_cfg.phase;
            end
            // Slot contents survive a clear; only pointers, count and last flags are dropped.
            if (clear) begin
                wr_slot   <= '0;
                play_slot <= '0;
                occ       <= '0;
                last_q    <= '0;
            end else begin
                if (wr_en) begin
                    wr_slot         <= wr_slot + 1'b1;
                    last_q[wr_slot] <= wr_cfg.last;
                end
                if (play_reset)
                    play_slot <= '0;
                else if (play_adv)
                    play_slot <= play_slot + 1'b1;
                case ({wr_en, play_adv})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    assign play_last = last_q[play_slot];

    for (genvar i = 0; i < N_BUF; i++) begin : g_pack
        assign start_all[i*PW +: PW]         = start_q[i];
        assign end_all[i*PW +: PW]           = end_q[i];
        assign step_all[i*PW +: PW]          = step_q[i];
        assign ncyc_all[i*NCYC_W +: NCYC_W]  = ncyc_q[i];
        assign amp_all[i*AMP_W +: AMP_W]     = amp_q[i];
        assign dc_all[i*DC_W +: DC_W]        = dc_q[i];
        assign phase_all[i*PH_W +: PH_W]     = phase_q[i];
    end

endmodule

// File: rtl/red_pitaya_asg_seg_sched.sv
// Segment scheduler for one multi-buffer ASG channel: descriptor intake plus channel sequencing FSM.
module red_pitaya_asg_seg_sched
    import asg_seq_pkg::*;
#(
    parameter int RSZ   = 14,
    parameter int N_BUF = 4,
    parameter int SW    = 2
) (
    input  logic                       dac_clk_i,
    input  logic                       dac_rst_i,
    input  logic                       desc_valid_i,
    output logic                       desc_ready_o,
    input  logic [RSZ+15:0]            desc_start_i,
    input  logic [RSZ+15:0]            desc_end_i,
    input  logic [RSZ+15:0]            desc_step_i,
    input  logic [15:0]                desc_ncyc_i,
    input  logic [13:0]                desc_amp_i,
    input  logic [13:0]                desc_dc_i,
    input  logic [1:0]                 desc_phase_i,
    input  logic                       desc_last_i,
    input  logic                       ctl_start_i,
    input  logic                       ctl_abort_i,
    input  logic [SW:0]                ctl_preload_i,
    input  logic                       buf_done_i,
    output logic [(RSZ+16)*N_BUF-1:0]  set_start_all_o,
    output logic [(RSZ+16)*N_BUF-1:0]  set_end_all_o,
    output logic [(RSZ+16)*N_BUF-1:0]  set_step_all_o,
    output logic [16*N_BUF-1:0]        set_ncyc_all_o,
    output logic [14*N_BUF-1:0]        set_amp_all_o,
    output logic [14*N_BUF-1:0]        set_dc_all_o,
    output logic [2*N_BUF-1:0]         set_phase_bits_all_o,
    output logic                       set_rst_o,
    output logic                       set_zero_o,
    output logic                       trig_sw_o,
    output logic [2:0]                 trig_src_o,
    output logic [SW:0]                occ_o,
    output logic [2:0]                 state_o,
    output logic [31:0]                seg_cnt_o,
    output logic                       done_o,
    output logic                       underrun_o
);
    sched_state_t state;
    seg_desc_t    desc_cfg;
    logic [SW:0]  occ;
    logic [SW:0]  need;
    logic         accept;
    logic         play_adv;
    logic         play_last;
    logic         ring_clear;

    assign desc_ready_o = (occ < (SW+1)'(N_BUF)) && !ctl_abort_i
                          && (state == ST_IDLE || state == ST_RUN);
    assign accept     = desc_valid_i && desc_ready_o;
    assign need       = (ctl_preload_i == '0) ? (SW+1)'(1) : ctl_preload_i;
    assign play_adv   = buf_done_i && (state == ST_RUN) && !ctl_abort_i && (occ != '0);
    assign ring_clear = ctl_abort_i || (state == ST_DONE);
    assign desc_cfg   = '{ncyc: desc_ncyc_i, amp: desc_amp_i, dc: desc_dc_i,
                          phase: desc_phase_i, last: desc_last_i};

    asg_slot_ring #(.RSZ(RSZ), .N_BUF(N_BUF), .SW(SW)) u_ring (
        .clk        (dac_clk_i),
        .rst        (dac_rst_i),
        .wr_en      (accept),
        .wr_start   (desc_start_i),
        .wr_end     (desc_end_i),
        .wr_step    (desc_step_i),
        .wr_cfg     (desc_cfg),
        .play_adv   (play_adv),
        .play_reset (state == ST_ARM),
        .clear      (ring_clear),
        .occ        (occ),
        .play_last  (play_last),
        .start_all  (set_start_all_o),
        .end_all    (set_end_all_o),
        .step_all   (set_step_all_o),
        .ncyc_all   (set_ncyc_all_o),
        .amp_all    (set_amp_all_o),
        .dc_all     (set_dc_all_o),
        .phase_all  (set_phase_bits_all_o)
    );

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state      <= ST_IDLE;
            set_rst_o  <= 1'b1;
            set_zero_o <= 1'b1;
            trig_sw_o  <= 1'b0;
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
            seg_cnt_o  <= '0;
        end else begin
            trig_sw_o <= 1'b0;
            done_o    <= 1'b0;
            if (ctl_abort_i) begin
                state      <= ST_IDLE;
                set_rst_o  <= 1'b1;
                set_zero_o <= 1'b1;
                underrun_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        set_rst_o  <= 1'b1;
                        set_zero_o <= 1'b1;
                        if (ctl_start_i && occ >= need) begin
                            state      <= ST_ARM;
                            set_rst_o  <= 1'b0;
                            set_zero_o <= 1'b0;
                            seg_cnt_o  <= '0;
                        end
                    end
                    ST_ARM: begin
                        state     <= ST_RUN;
                        trig_sw_o <= 1'b1;
                    end
                    ST_RUN: begin
                        // Stop/zero land one cycle after buf_done; the channel pipeline hides that cycle.
                        if (play_adv) begin
                            seg_cnt_o <= seg_cnt_o + 32'd1;
                            if (play_last) begin
                                state      <= ST_DONE;
                                done_o     <= 1'b1;
                                set_rst_o  <= 1'b1;
                                set_zero_o <= 1'b1;
                            end else if (occ == (SW+1)'(1) && !accept) begin
                                state      <= ST_FAULT;
                                underrun_o <= 1'b1;
                                set_rst_o  <= 1'b1;
                                set_zero_o <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    ST_FAULT: begin
                        set_rst_o  <= 1'b1;
                        set_zero_o <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign occ_o      = occ;
    assign state_o    = state;
    assign trig_src_o = 3'd1;

endmodule

// File: doc/red_pitaya_asg_seg_sched.md
Name: red_pitaya_asg_seg_sched

Overview:
- Segment scheduler for one multi-buffer ASG channel.
- Keeps a ring of N_BUF configuration slots that drive the channel's packed per-buffer config buses. Software pushes segment descriptors through a valid/ready port, and the block refills each slot as soon as the channel reports that slot finished (buf_done).
- Sequences the channel: holds it in reset while idle, releases it, fires the software trigger, and stops or zeroes it at end of stream or on underrun.
- Sits between the ASG register bank and the channel instance.

Parameters:
RSZ, 14, buffer address width; pointer fields are RSZ+16 bits
N_BUF, 4, slot count; must be a power of 2 and equal the channel's buffer count (channel slot index wraps modulo N_BUF)
SW, 2, slot index width, log2(N_BUF)

Ports:
dac_clk_i  in  1  clock
dac_rst_i  in  1  reset, synchronous, active-high
desc_valid_i  in  1  descriptor offered
desc_ready_o  out  1  descriptor accepted when valid&ready
desc_start_i  in  RSZ+16  start pointer
desc_end_i  in  RSZ+16  end pointer
desc_step_i  in  RSZ+16  pointer step
desc_ncyc_i  in  16  cycle count
desc_amp_i  in  14  amplitude
desc_dc_i  in  14  offset
desc_phase_i  in  2  phase bits
desc_last_i  in  1  final segment of stream
ctl_start_i  in  1  start pulse
ctl_abort_i  in  1  abort pulse
ctl_preload_i  in  SW+1  slots required before start, 1..N_BUF (0 treated as 1)
buf_done_i  in  1  channel slot-complete pulse
set_start_all_o, set_end_all_o, set_step_all_o  out  (RSZ+16)*N_BUF  packed slot config
set_ncyc_all_o  out  16*N_BUF  packed slot config
set_amp_all_o, set_dc_all_o  out  14*N_BUF  packed slot config
set_phase_bits_all_o  out  2*N_BUF  packed slot config
set_rst_o  out  1  channel FSM reset
set_zero_o  out  1  channel output zero
trig_sw_o  out  1  channel software trigger
trig_src_o  out  3  constant 3'd1
occ_o  out  SW+1  loaded-slot count
state_o  out  3  FSM state
seg_cnt_o  out  32  completed segments since start
done_o  out  1  1-cycle end-of-stream pulse
underrun_o  out  1  sticky underrun flag

Behaviour:
- Reset values:
  - state IDLE; wr_slot, play_slot, occ = 0; seg_cnt_o = 0.
  - All packed config outputs 0; last-flags 0.
  - set_rst_o = 1; set_zero_o = 1; trig_sw_o = 0; done_o = 0; underrun_o = 0.
- Accept: desc_ready_o = (occ < N_BUF) and state in {IDLE, RUN}.
  - On accept, write slot wr_slot and its last flag.
  - Written fields appear on the packed buses the next cycle.
  - wr_slot increments, wrapping modulo N_BUF.
  - A loaded, unplayed slot is never overwritten.
- occ update: +1 on accept, -1 on buf_done_i in RUN; both in the same cycle leaves occ unchanged.
- States: IDLE=0, ARM=1, RUN=2, DONE=3, FAULT=4.
- IDLE:
  - set_rst_o = 1, set_zero_o = 1.
  - ctl_start_i with occ >= max(ctl_preload_i, 1) -> ARM.
  - ctl_start_i with insufficient occ is ignored.
- ARM (1 cycle):
  - set_rst_o and set_zero_o go 0 on entry.
  - play_slot = 0, because the channel restarts at buffer 0.
  - Next state is RUN.
- RUN:
  - trig_sw_o = 1 in the first RUN cycle only.
  - On buf_done_i: seg_cnt_o + 1; play_slot wraps +1.
  - If last flag of play_slot = 1 -> DONE.
  - Else if occ = 1 and no simultaneous accept -> FAULT (underrun).
  - buf_done_i in IDLE, ARM, DONE or FAULT is ignored.
- DONE (1 cycle):
  - done_o = 1; set_rst_o = 1; set_zero_o = 1.
  - wr_slot, play_slot, occ and last flags cleared; remaining slots discarded.
  - Next state is IDLE.
- FAULT:
  - underrun_o set (sticky); set_zero_o = 1; set_rst_o = 1.
  - desc_ready_o = 0.
  - Exit only via ctl_abort_i.
- Outputs set_zero_o and set_rst_o are registered: asserted one cycle after the terminating buf_done_i. The channel's ≥3-cycle sample pipeline guarantees no sample of the following slot reaches dac_o.
- ctl_abort_i:
  - Any state -> IDLE next cycle.
  - Pointers, occ and last flags cleared; underrun_o cleared; seg_cnt_o kept.
  - Abort has priority over accept, start and buf_done in the same cycle; a descriptor offered that cycle is not accepted (desc_ready_o = 0 while ctl_abort_i is high).
- dac_rst_i overrides everything and returns all outputs to their reset values.

Decomposition:
- Shared package asg_seq_pkg holds:
  - state encodings;
  - descriptor field widths as functions of RSZ;
  - a packed descriptor struct.
- One natural sub-module, asg_slot_ring: slot storage, wr_slot/play_slot/occ counters and packing onto the *_all buses. The FSM stays in the top level.

Test Plan:
- Push 2 descriptors (ncyc 1, last on the 2nd), preload 2, start -> set_rst_o falls the cycle after start; trig_sw_o 1 cycle later. After 2 buf_done pulses: done_o 1 cycle, seg_cnt_o = 2, set_zero_o = 1.
- Fill 4 slots, try a 5th -> desc_ready_o = 0. Pulse buf_done_i -> slot 0 frees; 5th descriptor written into slot 0; occ stays 4.
- Accept and buf_done_i in the same cycle with occ = 1 -> no underrun; occ stays 1; play_slot advances.
- 3 non-last descriptors, 3 buf_done pulses with no refill -> FAULT on the 3rd; underrun_o = 1; set_zero_o = 1 next cycle; desc_ready_o = 0. ctl_abort_i -> IDLE; underrun_o = 0.
- Start with occ = 1 and ctl_preload_i = 3 -> stays IDLE. Add 2 descriptors, start again -> ARM.
- Mid-RUN, ctl_abort_i coincident with buf_done_i and desc_valid_i -> IDLE; occ = 0; set_rst_o = 1; descriptor not accepted. dac_rst_i mid-RUN -> all reset values.
